// File: rtl/sa_ram_rd_streamer_if.sv
// sa_ram_rd_streamer_if
//   Bundles the command, RAM read port and output stream signals of the
//   SA RAM read-side streamer.
//   master : the streamer (accepts commands, drives RAM reads, sources stream)
//   slave  : the environment (command source, RAM, stream consumer)
//   Signals:
//     cmd_valid/cmd_ready/cmd_addr[8:0]/cmd_len[8:0] : burst command
//     ram_re/ram_ra[8:0]/ram_dout[255:0]             : RAM read port
//     dout_valid/dout_ready/dout_data[255:0]/dout_last : output stream
interface sa_ram_rd_streamer_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [8:0]   cmd_addr;
  logic [8:0]   cmd_len;
  logic         ram_re;
  logic [8:0]   ram_ra;
  logic [255:0] ram_dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [255:0] dout_data;
  logic         dout_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, dout_ready,
    output cmd_ready, ram_re, ram_ra, dout_valid, dout_data, dout_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, dout_ready,
    input  cmd_ready, ram_re, ram_ra, dout_valid, dout_data, dout_last
  );
endinterface

// File: rtl/sa_ram_rd_streamer.sv
// sa_ram_rd_streamer
//   Read-side streaming controller for the 512x256 two-port SA RAM. Takes a
//   burst command (start address, length-1), issues one RAM read per cycle
//   while issue credits remain, absorbs the RAM's one-cycle read latency and
//   delivers the words on a valid/ready stream with a last marker.
//   Parameters:
//     DEPTH           : output FIFO entries == issue credits (>= 3 for full rate)
//   Ports:
//     nvdla_core_clk  : clock
//     nvdla_core_rstn : asynchronous active-low reset
//     rd_if           : command / RAM read port / output stream (master side)
//     busy            : controller not idle
//     stall_cnt[31:0] : cycles with dout_valid && !dout_ready (saturating)
//   Optional feature macro:
//     SA_RAM_RD_STREAMER_PERF_EN : enables stall_cnt; otherwise tied to 0.
module sa_ram_rd_streamer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  sa_ram_rd_streamer_if.master rd_if,
  output logic                 busy,
  output logic [31:0]          stall_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [8:0]    rd_ptr_q, rd_ptr_d;
  logic [8:0]    remaining_q, remaining_d;
  logic [8:0]    ra_hold_q;
  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_idx_q, rd_idx_q;
  logic          infl_vld_q, infl_last_q;
  logic [256:0]  fifo_mem [DEPTH];
  logic [256:0]  head;
  logic          dout_valid;
  logic          issue, pop, accept;

  function automatic logic [AW-1:0] idx_next(input logic [AW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + AW'(1);
  endfunction

  assign head       = fifo_mem[rd_idx_q];
  assign dout_valid = (count_q != '0);
  assign pop        = dout_valid & rd_if.dout_ready;
  assign accept     = rd_if.cmd_valid & (state_q == IDLE);
  assign issue      = (state_q == RUN) && (credits_q != '0);

  assign rd_if.cmd_ready  = (state_q == IDLE);
  assign rd_if.ram_re     = issue;
  // The address register only updates on issue, so the RAM sees a stable
  // address whenever no read is being made.
  assign rd_if.ram_ra     = issue ? rd_ptr_q : ra_hold_q;
  assign rd_if.dout_valid = dout_valid;
  // Storage has no reset; masking the head keeps the outputs at zero while
  // the FIFO is empty.
  assign rd_if.dout_data  = dout_valid ? head[255:0] : '0;
  assign rd_if.dout_last  = dout_valid & head[256];
  assign busy             = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_ptr_d    = rd_if.cmd_addr;
          remaining_d = rd_if.cmd_len;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + 9'd1;
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == '0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head[256]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (pop && !issue) begin
      credits_d = credits_q + CW'(1);
    end
    count_d = count_q;
    if (infl_vld_q && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !infl_vld_q) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      ra_hold_q   <= '0;
      credits_q   <= CW'(DEPTH);
      count_q     <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      infl_vld_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      credits_q   <= credits_d;
      count_q     <= count_d;
      infl_vld_q  <= issue;
      infl_last_q <= issue && (remaining_q == '0);
      if (issue) begin
        ra_hold_q <= rd_ptr_q;
      end
      if (infl_vld_q) begin
        wr_idx_q <= idx_next(wr_idx_q);
      end
      if (pop) begin
        rd_idx_q <= idx_next(rd_idx_q);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (infl_vld_q) begin
      fifo_mem[wr_idx_q] <= {infl_last_q, rd_if.ram_dout};
    end
  end

`ifdef SA_RAM_RD_STREAMER_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt_q <= '0;
    end else if (dout_valid && !rd_if.dout_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_ram_rd_streamer.sv
module tb_sa_ram_rd_streamer;

  localparam int DEPTH = 4;
`ifdef SA_RAM_RD_STREAMER_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct {
    logic [8:0] addr;
    logic [8:0] len;
    int         mode;        // 0: ready high, 1: random + 10-cycle low window, 2: low k=6..10
    int         exp_beats;
    logic [8:0] exp_last_ra;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic busy;
  logic [31:0] stall_cnt;
  logic [255:0] ram_mem [512];
  logic [8:0] last_ra_seen;
  int n_vec = 0;
  int n_err = 0;
  int model_stalls = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  sa_ram_rd_streamer_if bus ();

  sa_ram_rd_streamer #(.DEPTH(DEPTH)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .rd_if          (bus.master),
    .busy           (busy),
    .stall_cnt      (stall_cnt)
  );

  // RAM model: registered address, data valid the cycle after ram_re
  initial bus.ram_dout = '0;
  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_dout <= ram_mem[bus.ram_ra];
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string p);
    chki({p, "_cmd_ready"}, int'(bus.cmd_ready), 1);
    chki({p, "_ram_re"}, int'(bus.ram_re), 0);
    chki({p, "_ram_ra"}, int'(bus.ram_ra), 0);
    chki({p, "_dout_valid"}, int'(bus.dout_valid), 0);
    chk ({p, "_dout_data"}, bus.dout_data, '0);
    chki({p, "_dout_last"}, int'(bus.dout_last), 0);
    chki({p, "_busy"}, int'(busy), 0);
    chk ({p, "_stall_cnt"}, 256'(stall_cnt), '0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rstn = 1'b1;
    model_stalls = 0;
    last_ra_seen = '0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // cycle after the last pop, so back-to-back calls test issue at L+2.
  task automatic run_burst(input string tag, input logic [8:0] a, input logic [8:0] l,
                           input int mode, input int exp_beats, input logic [8:0] exp_last_ra);
    logic [8:0]   ra_q [$];
    logic [255:0] dq [$];
    logic         lq [$];
    logic [8:0]   ea;
    logic [255:0] prev_data;
    logic         prev_last, prev_stall, done;
    int k, first_re, first_v, first_beat_k, last_beat_k, outstanding, max_out;
    k = 0; first_re = -1; first_v = -1; first_beat_k = -1; last_beat_k = -1;
    outstanding = 0; max_out = 0; done = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;

    chki({tag, "_cmd_ready_idle"}, int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_len = l;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
      bus.cmd_valid = 1'b0;
      case (mode)
        0: bus.dout_ready = 1'b1;
        1: bus.dout_ready = (k >= 8 && k < 18) ? 1'b0 : 1'($urandom_range(0, 1));
        default: bus.dout_ready = !(k >= 6 && k <= 10);
      endcase
      if (mode == 1) begin
        // commands offered outside IDLE must be ignored
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_addr = 9'($urandom);
        bus.cmd_len = 9'($urandom);
      end
      if (bus.ram_re) begin
        ra_q.push_back(bus.ram_ra);
        last_ra_seen = bus.ram_ra;
        outstanding++;
        if (first_re < 0) first_re = k;
      end else begin
        chki({tag, "_ra_hold"}, int'(bus.ram_ra), int'(last_ra_seen));
      end
      if (outstanding > max_out) max_out = outstanding;
      if (bus.dout_valid && first_v < 0) first_v = k;
      if (prev_stall) begin
        chki({tag, "_hold_valid"}, int'(bus.dout_valid), 1);
        chk ({tag, "_hold_data"}, bus.dout_data, prev_data);
        chki({tag, "_hold_last"}, int'(bus.dout_last), int'(prev_last));
      end
      if (bus.dout_valid && bus.dout_ready) begin
        dq.push_back(bus.dout_data);
        lq.push_back(bus.dout_last);
        outstanding--;
        if (first_beat_k < 0) first_beat_k = k;
        if (bus.dout_last) begin
          done = 1'b1;
          last_beat_k = k;
          bus.cmd_valid = 1'b0;
        end
      end
      if (bus.dout_valid && !bus.dout_ready) model_stalls++;
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_data = bus.dout_data;
      prev_last = bus.dout_last;
    end
    bus.cmd_valid = 1'b0;

    chki({tag, "_burst_done"}, int'(done), 1);
    chki({tag, "_n_issue"}, ra_q.size(), exp_beats);
    for (int i = 0; i < ra_q.size() && i < exp_beats; i++) begin
      ea = a + 9'(i);
      chki($sformatf("%s_ra[%0d]", tag, i), int'(ra_q[i]), int'(ea));
    end
    if (ra_q.size() > 0) chki({tag, "_last_ra"}, int'(ra_q[ra_q.size()-1]), int'(exp_last_ra));
    chki({tag, "_n_beats"}, dq.size(), exp_beats);
    for (int i = 0; i < dq.size() && i < exp_beats; i++) begin
      ea = a + 9'(i);
      chk ($sformatf("%s_data[%0d]", tag, i), dq[i], ram_mem[ea]);
      chki($sformatf("%s_last[%0d]", tag, i), int'(lq[i]), (i == exp_beats - 1) ? 1 : 0);
    end
    chki({tag, "_first_re_cycle"}, first_re, 1);
    chki({tag, "_first_valid_cycle"}, first_v, 3);
    if (mode == 0) chki({tag, "_back_to_back"}, last_beat_k - first_beat_k, int'(l));
    chki({tag, "_outstanding_le_depth"}, int'(max_out <= DEPTH), 1);

    @(negedge clk);
    chki({tag, "_cmd_ready_after"}, int'(bus.cmd_ready), 1);
    chki({tag, "_busy_after"}, int'(busy), 0);
    chki({tag, "_valid_after"}, int'(bus.dout_valid), 0);
    chk ({tag, "_stall_cnt"}, 256'(stall_cnt), PERF_ON ? 256'(model_stalls) : '0);
  endtask

  initial begin
    logic [8:0] ra, rl;
    int beats, k, mode;
    logic stale;

    for (int i = 0; i < 512; i++)
      for (int j = 0; j < 8; j++) ram_mem[i][j*32 +: 32] = $urandom;
    ram_mem[5] = {8{32'hA5A5_0005}};

    vecs[0] = '{9'd5,   9'd0,   0, 1,   9'd5};    // single word
    vecs[1] = '{9'd510, 9'd3,   0, 4,   9'd1};    // address wrap
    vecs[2] = '{9'd0,   9'd511, 0, 512, 9'd511};  // full RAM
    vecs[3] = '{9'd37,  9'd15,  1, 16,  9'd52};   // backpressure
    vecs[4] = '{9'd511, 9'd0,   1, 1,   9'd511};
    vecs[5] = '{9'd300, 9'd20,  0, 21,  9'd320};

    do_reset();

    for (int v = 0; v < 6; v++)
      run_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].mode,
                vecs[v].exp_beats, vecs[v].exp_last_ra);

    for (int r = 0; r < 6; r++) begin
      ra = 9'($urandom_range(0, 511));
      rl = 9'($urandom_range(0, 40));
      mode = $urandom_range(0, 1);
      run_burst($sformatf("rnd%0d", r), ra, rl, mode, int'(rl) + 1, ra + rl);
    end

    // reset in the middle of a len=15 burst after three beats
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 9'd40;
    bus.cmd_len = 9'd15;
    bus.dout_ready = 1'b1;
    beats = 0;
    k = 0;
    while (beats < 3 && k < 60) begin
      @(negedge clk);
      k++;
      bus.cmd_valid = 1'b0;
      if (bus.dout_valid && bus.dout_ready) beats++;
    end
    chki("midrst_three_beats", beats, 3);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    check_reset_values("midrst_hold");
    rstn = 1'b1;
    model_stalls = 0;
    last_ra_seen = '0;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stale = stale | bus.dout_valid | bus.ram_re | busy;
    end
    chki("midrst_no_stale", int'(stale), 0);
    run_burst("post_rst", 9'd100, 9'd1, 0, 2, 9'd101);

    // stall counter: ready low for 5 cycles while valid
    do_reset();
    run_burst("perf", 9'd200, 9'd7, 2, 8, 9'd207);
    chk("perf_stall_total", 256'(stall_cnt), PERF_ON ? 256'(5) : '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
